ir: RTL and testbench
=====================

IR -- requirements
Module: ir

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the instruction word width in bits.
REQ-002 The block SHALL have parameter OPC_W, default 4, meaning the opcode field width; the operand width is DATA_W-OPC_W, which is 4 by default.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port load, input, 1 bit, the capture enable for din.
REQ-006 The block SHALL have port din, input, DATA_W bits, the instruction word from the bus.
REQ-007 The block SHALL have port opcode, output, OPC_W bits, the upper field of the stored word.
REQ-008 The block SHALL have port operand, output, DATA_W-OPC_W bits, the lower field of the stored word.

Function
REQ-009 The block SHALL hold one DATA_W-bit instruction register, IR.
REQ-010 On a rising clk edge with reset=0 and load=1, IR SHALL take the value of din sampled at that edge.
REQ-011 On a rising clk edge with reset=0 and load=0, IR SHALL hold its value, regardless of din.
REQ-012 opcode SHALL equal IR[DATA_W-1:DATA_W-OPC_W] at all times, through combinational decode of the register only.
REQ-013 operand SHALL equal IR[DATA_W-OPC_W-1:0] at all times, through combinational decode of the register only.
REQ-014 Load latency SHALL be one edge: new values appear on opcode/operand immediately after the capturing edge.
REQ-015 din changes between edges SHALL NOT affect the outputs; there is no combinational path from din or load to the outputs.
REQ-016 Back-to-back load=1 cycles SHALL capture din on every edge; the last capture wins.
REQ-017 The block SHALL have no handshake, busy or ready signalling; load is accepted on every cycle.
REQ-018 Any DATA_W >= 2 with 1 <= OPC_W < DATA_W SHALL be supported; other values are illegal and SHALL be flagged at elaboration.

Reset
REQ-019 On a rising clk edge with reset=1, IR SHALL become all zeros, so opcode=0 and operand=0.
REQ-020 reset SHALL take priority over load; reset=1 with load=1 clears IR and discards din.
REQ-021 Assertion or deassertion of reset between edges SHALL have no effect until the next rising edge.
REQ-022 After reset deasserts, IR SHALL stay at zero until the first edge with load=1.

Verification
REQ-023 Scenario: reset=1 for 2 edges with load=0 and din=00, then reset=0 -> opcode=0, operand=0.
REQ-024 Scenario: after reset, din=E5 and load=0 for one edge -> opcode=0, operand=0 (held).
REQ-025 Scenario: din=E5 and load=1 for one edge, then load=0 -> opcode=E, operand=5; this persists while din changes to 00.
REQ-026 Scenario: IR=E5, then reset=1 and load=1 with din=3A on the same edge -> opcode=0, operand=0.
REQ-027 Scenario: load=1 held for three edges with din=12, 34, F0 -> outputs 1/2, then 3/4, then F/0 on successive edges.
REQ-028 Scenario: IR=A7, then reset pulsed high between edges and low before the next edge -> outputs remain A/7.

Source files
------------

// File: rtl/ir.sv
// Instruction register: captures one bus word on load and splits it
// into a registered opcode field and a registered operand field.
module ir #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [DATA_W-1:0]       din,
  output logic [OPC_W-1:0]        opcode,
  output logic [DATA_W-OPC_W-1:0] operand
);

  localparam int OPD_W = DATA_W - OPC_W;

  if (DATA_W < 2 || OPC_W < 1 || OPC_W >= DATA_W) begin : g_bad_params
    $error("ir: need DATA_W >= 2 and 1 <= OPC_W < DATA_W");
  end

  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] ir_d;

  always_comb begin
    ir_d = ir_q;
    if (load) ir_d = din;
  end

  // reset is checked ahead of ir_d so it overrides a same-edge load
  always_ff @(posedge clk) begin
    if (reset) ir_q <= '0;
    else       ir_q <= ir_d;
  end

  assign opcode  = ir_q[DATA_W-1:OPD_W];
  assign operand = ir_q[OPD_W-1:0];

endmodule

// File: tb/tb_ir.sv
// Randomized bench for ir: a driver pushes the model's expected word per
// edge, a monitor pops it at the falling edge and checks both fields.
module tb_ir;

  localparam int DATA_W = 8;
  localparam int OPC_W  = 4;
  localparam int OPD_W  = DATA_W - OPC_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [OPC_W-1:0]  opcode;
  logic [OPD_W-1:0]  operand;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int model_word = 0;

  ir #(.DATA_W(DATA_W), .OPC_W(OPC_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .din     (din),
    .opcode  (opcode),
    .operand (operand)
  );

  always #5 clk = ~clk;

  // Monitor: one expected word per rising edge, checked mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        int w;
        int eop;
        int eopd;
        w    = exp_q.pop_front();
        eop  = w / (1 << OPD_W);
        eopd = w % (1 << OPD_W);
        checks++;
        if (int'(opcode) != eop) begin
          errors++;
          $display("FAIL opcode t=%0t got %h want %h", $time, opcode, eop);
        end
        checks++;
        if (int'(operand) != eopd) begin
          errors++;
          $display("FAIL operand t=%0t got %h want %h", $time, operand, eopd);
        end
      end
    end
  end

  // Called just after a rising edge. With glitch set, junk is placed on
  // every input across the next falling edge before the real values.
  task automatic cycle(input bit r, input bit l, input int d, input bit g);
    if (g) begin
      reset = 1'b1;
      load  = 1'b1;
      din   = DATA_W'($urandom);
      #6;
    end
    reset = r;
    load  = l;
    din   = DATA_W'(d);
    @(posedge clk);
    if (r)      model_word = 0;
    else if (l) model_word = d;
    exp_q.push_back(model_word);
    #1;
  endtask

  initial begin
    int n;
    #1;
    cycle(1, 0, 'h00, 0);
    cycle(1, 0, 'h00, 0);
    cycle(0, 0, 'h00, 0);
    cycle(0, 0, 'hE5, 0);
    cycle(0, 1, 'hE5, 0);
    cycle(0, 0, 'h00, 0);
    cycle(0, 0, 'h00, 0);
    cycle(1, 1, 'h3A, 0);
    cycle(0, 1, 'h12, 0);
    cycle(0, 1, 'h34, 0);
    cycle(0, 1, 'hF0, 0);
    cycle(0, 1, 'hA7, 0);
    cycle(0, 0, 'h5C, 1);
    cycle(0, 0, 'h00, 1);
    cycle(0, 1, 'hFF, 0);
    cycle(0, 0, 'h00, 1);
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, (1 << DATA_W) - 1)),
            $urandom_range(0, 7) == 0);
    end
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
